// File: rtl/vscr_pkg.sv
// Shared types and constants for the VSCR access controller.
// Build option: VSCR_MTVSCR_MASK_EN restricts mtvscr writes to the architected NJ and SAT bits.
package vscr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WB,
      WR_REQ
   } vscr_state_e;

   // Bit positions use big-endian numbering, so bit 31 is the LSB of the word.
   localparam int VSCR_NJ_BIT  = 15;
   localparam int VSCR_SAT_BIT = 31;
   localparam logic [31:0] VSCR_WR_MASK = (32'h1 << (31 - VSCR_NJ_BIT)) |
                                          (32'h1 << (31 - VSCR_SAT_BIT));

`ifdef VSCR_MTVSCR_MASK_EN
   localparam bit VSCR_MASK_EN = 1'b1;
`else
   localparam bit VSCR_MASK_EN = 1'b0;
`endif

   function automatic logic [31:0] vscr_wr_word(input logic [31:0] w);
      return VSCR_MASK_EN ? (w & VSCR_WR_MASK) : w;
   endfunction

endpackage

// File: rtl/vscr_wb_hold.sv
// Writeback hold register: data/address stay stable while valid is high, cleared on valid&ready or drop.
// One-cycle load-to-valid; ready only affects the registered valid, never combinationally.
module vscr_wb_hold #(
   parameter int VR_W = 128
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [4:0]      load_addr,
   input  logic [VR_W-1:0] load_data,
   input  logic            drop,
   output logic            rf_wr_valid,
   input  logic            rf_wr_ready,
   output logic [4:0]      rf_wr_addr,
   output logic [VR_W-1:0] rf_wr_data
);

   logic            valid_q, valid_d;
   logic [4:0]      addr_q, addr_d;
   logic [VR_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         addr_d  = load_addr;
         data_d  = load_data;
      end else if (drop || (valid_q && rf_wr_ready)) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign rf_wr_valid = valid_q;
   assign rf_wr_addr  = addr_q;
   assign rf_wr_data  = data_q;

endmodule

// File: rtl/vscr_access_ctrl.sv
// VSCR initiator: serialises mfvscr/mtvscr against SAT updates; mfvscr result to the RF in 3 cycles, mtvscr pulse in 1.
// Holds off dispatch (op_ready) while busy; watchdog abandons any wait after WAIT_LIMIT cycles and sets sticky err.
module vscr_access_ctrl
   import vscr_pkg::*;
#(
   parameter int VR_W       = 128,
   parameter int VSCR_W     = 32,
   parameter int WAIT_LIMIT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic              op_is_mt,
   input  logic [4:0]        op_vrt,
   input  logic [VR_W-1:0]   op_vrb,
   input  logic              sat_inflight,
   input  logic              pu_sat_en,
   input  logic              valu_sat_en,
   output logic              vscr_rd_en,
   output logic [4:0]        vscr_rd_tgt,
   output logic              vscr_wr_en,
   output logic [VSCR_W-1:0] vscr_wr_data,
   input  logic              vscr_rsp_en,
   input  logic [4:0]        vscr_rsp_tgt,
   input  logic [VSCR_W-1:0] vscr_rsp_data,
   output logic              rf_wr_valid,
   input  logic              rf_wr_ready,
   output logic [4:0]        rf_wr_addr,
   output logic [VR_W-1:0]   rf_wr_data,
   output logic              err
);

   localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

   vscr_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [4:0]        vrt_q, vrt_d;
   logic [VSCR_W-1:0] word_q, word_d;
   logic              err_q, err_d;
   logic              quiet, timeout, wb_load, wb_drop;
   logic              unused_vrb;

   assign unused_vrb = ^op_vrb[VR_W-1:VSCR_W];
   assign quiet      = ~sat_inflight & ~pu_sat_en & ~valu_sat_en;
   assign timeout    = (cnt_q == CNT_W'(WAIT_LIMIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         vrt_q   <= '0;
         word_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vrt_q   <= vrt_d;
         word_q  <= word_d;
         err_q   <= err_d;
      end
   end

   // Counter defaults to zero, so any state change clears it.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      vrt_d   = vrt_q;
      word_d  = word_q;
      err_d   = err_q;
      wb_load = 1'b0;
      wb_drop = 1'b0;
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               vrt_d   = op_vrt;
               word_d  = vscr_wr_word(op_vrb[VSCR_W-1:0]);
               state_d = op_is_mt ? WR_REQ : RD_REQ;
            end
         end
         RD_REQ, WR_REQ: begin
            if (quiet) begin
               state_d = (state_q == RD_REQ) ? RD_WAIT : IDLE;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD_WAIT: begin
            if (vscr_rsp_en && (vscr_rsp_tgt == vrt_q)) begin
               wb_load = 1'b1;
               state_d = WB;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         WB: begin
            if (rf_wr_ready) begin
               state_d = IDLE;
            end else if (timeout) begin
               err_d   = 1'b1;
               wb_drop = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      op_ready     = (state_q == IDLE);
      vscr_rd_en   = (state_q == RD_REQ) && quiet;
      vscr_wr_en   = (state_q == WR_REQ) && quiet;
      vscr_rd_tgt  = vscr_rd_en ? vrt_q : '0;
      vscr_wr_data = vscr_wr_en ? word_q : '0;
      err          = err_q;
   end

   vscr_wb_hold #(
      .VR_W(VR_W)
   ) u_wb_hold (
      .clk         (clk),
      .rst         (rst),
      .load        (wb_load),
      .load_addr   (vrt_q),
      .load_data   ({{(VR_W-VSCR_W){1'b0}}, vscr_rsp_data}),
      .drop        (wb_drop),
      .rf_wr_valid (rf_wr_valid),
      .rf_wr_ready (rf_wr_ready),
      .rf_wr_addr  (rf_wr_addr),
      .rf_wr_data  (rf_wr_data)
   );

endmodule

// File: tb/tb_vscr_access_ctrl.sv
// Directed bench for vscr_access_ctrl; honours VSCR_MTVSCR_MASK_EN for the expected write data.
module tb_vscr_access_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         op_valid, op_ready, op_is_mt;
   logic [4:0]   op_vrt;
   logic [127:0] op_vrb;
   logic         sat_inflight, pu_sat_en, valu_sat_en;
   logic         vscr_rd_en, vscr_wr_en;
   logic [4:0]   vscr_rd_tgt;
   logic [31:0]  vscr_wr_data;
   logic         vscr_rsp_en;
   logic [4:0]   vscr_rsp_tgt;
   logic [31:0]  vscr_rsp_data;
   logic         rf_wr_valid, rf_wr_ready;
   logic [4:0]   rf_wr_addr;
   logic [127:0] rf_wr_data;
   logic         err;

   int n_checks = 0;
   int n_fail   = 0;
   logic rd_seen;

   always #5 clk = ~clk;

   vscr_access_ctrl u_dut (
      .clk           (clk),
      .rst           (rst),
      .op_valid      (op_valid),
      .op_ready      (op_ready),
      .op_is_mt      (op_is_mt),
      .op_vrt        (op_vrt),
      .op_vrb        (op_vrb),
      .sat_inflight  (sat_inflight),
      .pu_sat_en     (pu_sat_en),
      .valu_sat_en   (valu_sat_en),
      .vscr_rd_en    (vscr_rd_en),
      .vscr_rd_tgt   (vscr_rd_tgt),
      .vscr_wr_en    (vscr_wr_en),
      .vscr_wr_data  (vscr_wr_data),
      .vscr_rsp_en   (vscr_rsp_en),
      .vscr_rsp_tgt  (vscr_rsp_tgt),
      .vscr_rsp_data (vscr_rsp_data),
      .rf_wr_valid   (rf_wr_valid),
      .rf_wr_ready   (rf_wr_ready),
      .rf_wr_addr    (rf_wr_addr),
      .rf_wr_data    (rf_wr_data),
      .err           (err)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one op for a single cycle; returns 1ns into the cycle after acceptance.
   task automatic issue(input logic is_mt, input logic [4:0] vrt, input logic [127:0] vrb);
      op_valid = 1'b1;
      op_is_mt = is_mt;
      op_vrt   = vrt;
      op_vrb   = vrb;
      tick();
      op_valid = 1'b0;
      op_vrb   = '1;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   function automatic logic [31:0] exp_wr(input logic [31:0] w);
`ifdef VSCR_MTVSCR_MASK_EN
      return w & 32'h0001_0001;
`else
      return w;
`endif
   endfunction

   initial begin
      op_valid = 0; op_is_mt = 0; op_vrt = 0; op_vrb = '0;
      sat_inflight = 0; pu_sat_en = 0; valu_sat_en = 0;
      vscr_rsp_en = 0; vscr_rsp_tgt = 0; vscr_rsp_data = 0;
      rf_wr_ready = 1;
      do_reset();

      check("rst_op_ready", op_ready, 1);
      check("rst_rd_en", vscr_rd_en, 0);
      check("rst_wr_en", vscr_wr_en, 0);
      check("rst_rf_valid", rf_wr_valid, 0);
      check("rst_rf_data", rf_wr_data, 0);
      check("rst_err", err, 0);

      // mfvscr, quiet, ready: rd_en N+1, rsp N+2, valid N+3
      issue(1'b0, 5'd7, 128'h0);
      check("mf_rd_en", vscr_rd_en, 1);
      check("mf_rd_tgt", vscr_rd_tgt, 7);
      check("mf_busy", op_ready, 0);
      tick();
      vscr_rsp_en = 1; vscr_rsp_tgt = 5'd7; vscr_rsp_data = 32'h0001_0001;
      #1;
      check("mf_rd_single", vscr_rd_en, 0);
      tick();
      vscr_rsp_en = 0; vscr_rsp_data = 32'hFFFF_FFFF;
      #1;
      check("mf_wb_valid", rf_wr_valid, 1);
      check("mf_wb_addr", rf_wr_addr, 7);
      check("mf_wb_data", rf_wr_data, {96'h0, 32'h0001_0001});
      tick();
      check("mf_wb_done", rf_wr_valid, 0);
      check("mf_idle", op_ready, 1);

      // mtvscr, quiet: wr_en N+1
      issue(1'b1, 5'd0, {96'hA5A5_5A5A_0F0F_F0F0_1234_5678, 32'hFFFF_FFFF});
      check("mt_wr_en", vscr_wr_en, 1);
      check("mt_wr_data", vscr_wr_data, exp_wr(32'hFFFF_FFFF));
      check("mt_no_rd", vscr_rd_en, 0);
      tick();
      check("mt_wr_single", vscr_wr_en, 0);
      check("mt_idle", op_ready, 1);

      // mtvscr held off by PU SAT for 3 cycles
      pu_sat_en = 1;
      issue(1'b1, 5'd0, {96'h0, 32'h8001_0003});
      for (int i = 0; i < 3; i++) begin
         check("mt_sat_hold_wr", vscr_wr_en, 0);
         check("mt_sat_hold_rdy", op_ready, 0);
         tick();
      end
      pu_sat_en = 0;
      #1;
      check("mt_sat_wr_en", vscr_wr_en, 1);
      check("mt_sat_wr_data", vscr_wr_data, exp_wr(32'h8001_0003));
      tick();
      check("mt_sat_idle", op_ready, 1);

      // VALU SAT in the would-be pulse cycle forces a retry
      valu_sat_en = 1;
      issue(1'b1, 5'd0, {96'h0, 32'h0001_0000});
      check("mt_valu_hold", vscr_wr_en, 0);
      tick();
      valu_sat_en = 0;
      #1;
      check("mt_valu_retry", vscr_wr_en, 1);
      tick();

      // mfvscr with RF backpressure: held stable, op_ready back after handshake
      rf_wr_ready = 0;
      issue(1'b0, 5'd12, 128'h0);
      tick();
      vscr_rsp_en = 1; vscr_rsp_tgt = 5'd12; vscr_rsp_data = 32'hDEAD_BEEF;
      tick();
      vscr_rsp_en = 0; vscr_rsp_data = 32'h1111_2222;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("bp_valid", rf_wr_valid, 1);
         check("bp_addr", rf_wr_addr, 12);
         check("bp_data", rf_wr_data, {96'h0, 32'hDEAD_BEEF});
         check("bp_busy", op_ready, 0);
         tick();
      end
      rf_wr_ready = 1;
      #1;
      check("bp_valid_at_rdy", rf_wr_valid, 1);
      tick();
      check("bp_done", rf_wr_valid, 0);
      check("bp_idle", op_ready, 1);

      // target mismatch on the read return
      issue(1'b0, 5'd7, 128'h0);
      tick();
      vscr_rsp_en = 1; vscr_rsp_tgt = 5'd3; vscr_rsp_data = 32'h0000_00FF;
      tick();
      vscr_rsp_en = 0;
      #1;
      check("mm_err", err, 1);
      check("mm_no_valid", rf_wr_valid, 0);
      check("mm_idle", op_ready, 1);
      for (int i = 0; i < 5; i++) tick();
      check("mm_err_sticky", err, 1);
      do_reset();
      check("mm_err_cleared", err, 0);

      // missing read return
      issue(1'b0, 5'd4, 128'h0);
      tick();
      tick();
      check("norsp_err", err, 1);
      check("norsp_no_valid", rf_wr_valid, 0);
      do_reset();

      // watchdog: SAT in flight for the whole read request
      sat_inflight = 1;
      rd_seen = 0;
      issue(1'b0, 5'd9, 128'h0);
      for (int i = 0; i < 250; i++) begin
         if (vscr_rd_en) rd_seen = 1;
         tick();
      end
      check("wd_not_yet", err, 0);
      check("wd_busy", op_ready, 0);
      for (int i = 0; i < 10; i++) begin
         if (vscr_rd_en) rd_seen = 1;
         tick();
      end
      check("wd_err", err, 1);
      check("wd_idle", op_ready, 1);
      check("wd_no_rd", rd_seen, 0);
      sat_inflight = 0;
      do_reset();

      // reset while holding a writeback
      rf_wr_ready = 0;
      issue(1'b0, 5'd21, 128'h0);
      tick();
      vscr_rsp_en = 1; vscr_rsp_tgt = 5'd21; vscr_rsp_data = 32'h0BAD_F00D;
      tick();
      vscr_rsp_en = 0;
      #1;
      check("rstwb_valid", rf_wr_valid, 1);
      rst = 1;
      tick();
      check("rstwb_valid_clr", rf_wr_valid, 0);
      check("rstwb_idle", op_ready, 1);
      rst = 0;
      rf_wr_ready = 1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
